// File: rtl/isa_pkg.sv
// isa_pkg: opcodes, ALU selector codes, field positions and control bundle type
package isa_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ANDI = 4'h5;
  localparam logic [3:0] OP_ORI  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [1:0] ALU_SEL_ADDSUB = 2'd0;
  localparam logic [1:0] ALU_SEL_LOGIC  = 2'd1;
  localparam logic [1:0] ALU_SEL_PASS   = 2'd2;
  localparam logic LOGIC_OR  = 1'b0;
  localparam logic LOGIC_AND = 1'b1;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int IMM_LSB = 0;
  typedef struct packed {
    logic [1:0] alu_sel;
    logic       logic_op;
    logic       alu_sub;
    logic       use_imm;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       hlt;
  } ctrl_t;
endpackage

// File: rtl/instr_decode_comb.sv
// instr_decode_comb: combinational opcode to datapath control table
module instr_decode_comb
  import isa_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);
  // opcode lookup; undefined opcodes yield an all-zero bundle flagged illegal
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_NOP: ;
      OP_ADD: ctrl.reg_we = 1'b1;
      OP_SUB: begin
        ctrl.alu_sub = 1'b1;
        ctrl.reg_we  = 1'b1;
      end
      OP_AND, OP_ANDI: begin
        ctrl.alu_sel  = ALU_SEL_LOGIC;
        ctrl.logic_op = LOGIC_AND;
        ctrl.use_imm  = opcode == OP_ANDI;
        ctrl.reg_we   = 1'b1;
      end
      OP_OR, OP_ORI: begin
        ctrl.alu_sel  = ALU_SEL_LOGIC;
        ctrl.logic_op = LOGIC_OR;
        ctrl.use_imm  = opcode == OP_ORI;
        ctrl.reg_we   = 1'b1;
      end
      OP_LDI: begin
        ctrl.alu_sel = ALU_SEL_PASS;
        ctrl.use_imm = 1'b1;
        ctrl.reg_we  = 1'b1;
      end
      OP_LD: begin
        ctrl.use_imm = 1'b1;
        ctrl.mem_rd  = 1'b1;
        ctrl.reg_we  = 1'b1;
      end
      OP_ST: begin
        ctrl.use_imm = 1'b1;
        ctrl.mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_sel = ALU_SEL_ADDSUB;
        ctrl.alu_sub = 1'b1;
        ctrl.branch  = 1'b1;
      end
      OP_JMP: begin
        ctrl.jump    = 1'b1;
        ctrl.use_imm = 1'b1;
      end
      OP_HLT: ctrl.hlt = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode stage with valid/ready handshakes, halt FSM and retire counter
module instr_decode_stage
  import isa_pkg::*;
#(
  parameter int IW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IW-1:0]    in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       rd,
  output logic [1:0]       rs,
  output logic [7:0]       imm,
  output logic [1:0]       alu_sel,
  output logic             logic_op,
  output logic             alu_sub,
  output logic             use_imm,
  output logic             reg_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic             halted,
  output logic             err_sticky,
  input  logic             resume,
  output logic [CNT_W-1:0] dec_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_d;
  ctrl_t dec, ctrl_q;
  logic [11:0] fields_q;
  logic xfer, acc;
  instr_decode_comb u_comb (.opcode(in_instr[OPC_LSB+:4]), .ctrl(dec));
  assign in_ready = (state == RUN) & (~out_valid | out_ready);
  assign xfer = in_valid & in_ready;
  assign acc = out_valid & out_ready;
  assign halted = state == HALT;
  assign {rd, rs, imm} = fields_q;
  assign {alu_sel, logic_op, alu_sub, use_imm, reg_we, mem_rd, mem_wr, branch, jump, illegal} =
    {ctrl_q.alu_sel, ctrl_q.logic_op, ctrl_q.alu_sub, ctrl_q.use_imm, ctrl_q.reg_we,
     ctrl_q.mem_rd, ctrl_q.mem_wr, ctrl_q.branch, ctrl_q.jump, ctrl_q.illegal};
  // halt entry on a registered HLT transfer, exit on resume
  always_comb begin
    state_d = state;
    if (state == RUN && xfer && dec.hlt) state_d = HALT;
    if (state == HALT && resume) state_d = RUN;
  end
  // state, output bundle, sticky error and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      out_valid  <= 1'b0;
      ctrl_q     <= '0;
      fields_q   <= '0;
      err_sticky <= 1'b0;
      dec_count  <= '0;
    end else begin
      state <= state_d;
      if (xfer) begin
        out_valid <= 1'b1;
        ctrl_q    <= dec;
        fields_q  <= in_instr[11:0];
      end else if (acc) begin
        out_valid <= 1'b0;
      end
      err_sticky <= err_sticky | (xfer & dec.illegal);
      dec_count  <= dec_count + CNT_W'(acc);
    end
  end
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed self-checking bench for instr_decode_stage
module tb_instr_decode_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, resume = 0;
  logic [15:0] in_instr = '0;
  logic in_ready, out_valid, logic_op, alu_sub, use_imm, reg_we, mem_rd, mem_wr, branch, jump;
  logic illegal, halted, err_sticky;
  logic [1:0] rd, rs, alu_sel;
  logic [7:0] imm;
  logic [3:0] dec_count;
  int checks = 0, errors = 0;
  localparam logic [10:0] C_AND  = {2'd1, 9'b100100000};
  localparam logic [10:0] C_OR   = {2'd1, 9'b000100000};
  localparam logic [10:0] C_ANDI = {2'd1, 9'b101100000};
  localparam logic [10:0] C_ADD  = {2'd0, 9'b000100000};
  localparam logic [10:0] C_SUB  = {2'd0, 9'b010100000};
  localparam logic [10:0] C_ILL  = {2'd0, 9'b000000001};
  localparam logic [10:0] C_LDI  = {2'd2, 9'b001100000};
  localparam logic [10:0] C_NONE = 11'd0;
  logic [10:0] ctl;
  assign ctl = {alu_sel, logic_op, alu_sub, use_imm, reg_we, mem_rd, mem_wr, branch, jump, illegal};

  instr_decode_stage #(.IW(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .rs(rs), .imm(imm),
    .alu_sel(alu_sel), .logic_op(logic_op), .alu_sub(alu_sub), .use_imm(use_imm),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .jump(jump),
    .illegal(illegal), .halted(halted), .err_sticky(err_sticky), .resume(resume),
    .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input string tag, input logic [10:0] c, input logic [11:0] f);
    chk({tag, ".valid"}, 32'(out_valid), 1);
    chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    chk({tag, ".fields"}, 32'({rd, rs, imm}), 32'(f));
  endtask

  initial begin
    step();
    step();
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.ctl", 32'(ctl), 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.err", 32'(err_sticky), 0);
    chk("rst.cnt", 32'(dec_count), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    rst_n = 1;
    out_ready = 1;
    in_valid = 1;
    in_instr = 16'h3412;
    step();
    bundle("and", C_AND, 12'h412);
    in_instr = 16'h4ABC;
    step();
    bundle("or", C_OR, 12'hABC);
    in_instr = 16'h5C0F;
    step();
    bundle("andi", C_ANDI, 12'hC0F);
    in_valid = 0;
    step();
    chk("stream.drain", 32'(out_valid), 0);
    chk("stream.cnt", 32'(dec_count), 3);
    out_ready = 0;
    in_valid = 1;
    in_instr = 16'h1000;
    step();
    in_instr = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      chk("bp.in_ready", 32'(in_ready), 0);
      bundle("bp.hold", C_ADD, 12'h000);
      step();
    end
    out_ready = 1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 1);
    step();
    bundle("bp.sub", C_SUB, 12'h000);
    chk("bp.cnt", 32'(dec_count), 4);
    in_valid = 0;
    step();
    chk("bp.drain", 32'(out_valid), 0);
    chk("bp.cnt2", 32'(dec_count), 5);
    in_valid = 1;
    in_instr = 16'hD123;
    step();
    bundle("ill", C_ILL, 12'h123);
    chk("ill.err", 32'(err_sticky), 1);
    in_instr = 16'h1ABC;
    step();
    bundle("ill.next", C_ADD, 12'hABC);
    chk("ill.err_keep", 32'(err_sticky), 1);
    in_valid = 0;
    step();
    chk("ill.cnt", 32'(dec_count), 7);
    in_valid = 1;
    in_instr = 16'hF000;
    step();
    bundle("hlt", C_NONE, 12'h000);
    chk("hlt.halted", 32'(halted), 1);
    chk("hlt.in_ready", 32'(in_ready), 0);
    in_instr = 16'h7055;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hlt.hold_ready", 32'(in_ready), 0);
      chk("hlt.hold_valid", 32'(out_valid), 0);
      chk("hlt.hold_halted", 32'(halted), 1);
    end
    chk("hlt.cnt", 32'(dec_count), 8);
    resume = 1;
    step();
    resume = 0;
    chk("res.halted", 32'(halted), 0);
    chk("res.in_ready", 32'(in_ready), 1);
    chk("res.valid", 32'(out_valid), 0);
    step();
    bundle("ldi", C_LDI, 12'h055);
    in_valid = 0;
    step();
    chk("ldi.cnt", 32'(dec_count), 9);
    out_ready = 0;
    in_valid = 1;
    in_instr = 16'hF0AA;
    step();
    chk("mid.pre_valid", 32'(out_valid), 1);
    chk("mid.pre_halted", 32'(halted), 1);
    rst_n = 0;
    in_valid = 0;
    step();
    chk("mid.valid", 32'(out_valid), 0);
    chk("mid.halted", 32'(halted), 0);
    chk("mid.err", 32'(err_sticky), 0);
    chk("mid.cnt", 32'(dec_count), 0);
    rst_n = 1;
    out_ready = 1;
    in_valid = 1;
    in_instr = 16'h1000;
    for (int i = 0; i < 17; i++) step();
    chk("wrap.16", 32'(dec_count), 0);
    in_valid = 0;
    step();
    chk("wrap.17", 32'(dec_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
